// File: rtl/satprotect_pipe_if.sv
// satprotect_pipe_if: sample bus for satprotect_pipe.
// master = sample source / status consumer, slave = the saturation pipeline.
interface satprotect_pipe_if #(
  parameter int RI    = 16,
  parameter int RO    = 14,
  parameter int CH    = 2,
  parameter int CNT_W = 8
);
  // Input side: one valid qualifies every channel lane.
  logic [CH*RI-1:0]    in;
  logic                in_valid;
  logic                clr;

  // Output side: samples, per-sample indicators and sticky status.
  logic [CH*RO-1:0]    out;
  logic                out_valid;
  logic [CH-1:0]       sat_pos;
  logic [CH-1:0]       sat_neg;
  logic [CH-1:0]       sat_flag;
  logic [CH*CNT_W-1:0] sat_cnt;

  modport master (
    output in, in_valid, clr,
    input  out, out_valid, sat_pos, sat_neg, sat_flag, sat_cnt
  );

  modport slave (
    input  in, in_valid, clr,
    output out, out_valid, sat_pos, sat_neg, sat_flag, sat_cnt
  );
endinterface

// File: rtl/satprotect_pipe.sv
// satprotect_pipe: two-stage per-channel scale-and-saturate pipeline.
//   stage 1: arithmetic right shift by SHIFT into an (RI-SHIFT+1)-bit value
//   stage 2: clamp to the RO-bit two's complement range, flag the clamp side
// Sticky per-channel flags and saturating counters track clamp events.
// Optional feature: define SATPROTECT_ROUND_EN for round-half-up in stage 1
// (default build truncates with floor semantics).
module satprotect_pipe #(
  parameter int RI    = 16,
  parameter int RO    = 14,
  parameter int SHIFT = 0,
  parameter int CH    = 2,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  satprotect_pipe_if.slave bus
);

  // Stage-1 intermediate width: one spare bit above the shifted sample so a
  // rounded result never wraps.
  localparam int W1 = RI - SHIFT + 1;
  // Comparison width: wide enough for both the intermediate and the output
  // range, plus a sign bit so the limits compare as signed quantities.
  localparam int WC = ((W1 > RO) ? W1 : RO) + 1;

  localparam logic signed [WC-1:0] MAX_C = {{(WC-RO+1){1'b0}}, {(RO-1){1'b1}}};
  localparam logic signed [WC-1:0] MIN_C = {{(WC-RO+1){1'b1}}, {(RO-1){1'b0}}};

  localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C = {{(CNT_W-1){1'b0}}, 1'b1};

`ifdef SATPROTECT_ROUND_EN
  // Half-LSB of the shifted result; zero when nothing is dropped.
  localparam int           RND_SH_C = (SHIFT > 0) ? (SHIFT - 1) : 0;
  localparam logic [RI:0]  RND_C    = (SHIFT > 0) ? ({{RI{1'b0}}, 1'b1} << RND_SH_C)
                                                  : {(RI+1){1'b0}};
`endif

  // Stage 1 registers.
  logic [CH*W1-1:0]    s1_data_d, s1_data_q;
  logic                s1_valid_d, s1_valid_q;

  // Stage 2 (output) registers.
  logic [CH*RO-1:0]    out_d, out_q;
  logic                out_valid_d, out_valid_q;
  logic [CH-1:0]       sat_pos_d, sat_pos_q;
  logic [CH-1:0]       sat_neg_d, sat_neg_q;

  // Status registers.
  logic [CH-1:0]       sat_flag_d, sat_flag_q;
  logic [CH*CNT_W-1:0] sat_cnt_d, sat_cnt_q;

  // A clamp event is a presented output sample carrying either indicator.
  logic [CH-1:0]       sat_ev_s;

  // Scale one RI-bit sample: sign-extend by one bit (room for the rounding
  // add, which cannot overflow because SHIFT <= RI-2), then shift right.
  function automatic logic [W1-1:0] scale(input logic [RI-1:0] x);
    logic signed [RI:0] ext;
    ext = $signed({x[RI-1], x});
`ifdef SATPROTECT_ROUND_EN
    ext = ext + $signed(RND_C);
`endif
    return W1'(ext >>> SHIFT);
  endfunction

  // Clamp one intermediate to the RO-bit range.
  // Result packing: {sat_pos, sat_neg, value[RO-1:0]}.
  function automatic logic [RO+1:0] saturate(input logic [W1-1:0] v);
    logic signed [WC-1:0] wide;
    wide = $signed({{(WC-W1){v[W1-1]}}, v});
    if (wide > MAX_C) begin
      return {1'b1, 1'b0, MAX_C[RO-1:0]};
    end else if (wide < MIN_C) begin
      return {1'b0, 1'b1, MIN_C[RO-1:0]};
    end else begin
      return {1'b0, 1'b0, wide[RO-1:0]};
    end
  endfunction

  assign sat_ev_s = {CH{out_valid_q}} & (sat_pos_q | sat_neg_q);

  // Stage 1: scale every lane, capturing data only on a valid input sample.
  always_comb begin
    s1_data_d  = s1_data_q;
    s1_valid_d = bus.in_valid;
    if (bus.in_valid) begin
      for (int k = 0; k < CH; k++) begin
        s1_data_d[k*W1 +: W1] = scale(bus.in[k*RI +: RI]);
      end
    end else begin
      s1_data_d = s1_data_q;
    end
  end

  // Stage 2: clamp every lane; data and indicators hold between valid samples.
  always_comb begin
    out_d       = out_q;
    sat_pos_d   = sat_pos_q;
    sat_neg_d   = sat_neg_q;
    out_valid_d = s1_valid_q;
    if (s1_valid_q) begin
      for (int k = 0; k < CH; k++) begin
        {sat_pos_d[k], sat_neg_d[k], out_d[k*RO +: RO]} = saturate(s1_data_q[k*W1 +: W1]);
      end
    end else begin
      out_d = out_q;
    end
  end

  // Status: sticky flags and saturating counters; an event coincident with
  // clr survives the clear as a fresh count of one.
  always_comb begin
    sat_flag_d = sat_flag_q;
    sat_cnt_d  = sat_cnt_q;
    for (int k = 0; k < CH; k++) begin
      if (bus.clr) begin
        if (sat_ev_s[k]) begin
          sat_flag_d[k]                = 1'b1;
          sat_cnt_d[k*CNT_W +: CNT_W]  = CNT_ONE_C;
        end else begin
          sat_flag_d[k]                = 1'b0;
          sat_cnt_d[k*CNT_W +: CNT_W]  = {CNT_W{1'b0}};
        end
      end else if (sat_ev_s[k]) begin
        sat_flag_d[k] = 1'b1;
        if (sat_cnt_q[k*CNT_W +: CNT_W] != CNT_MAX_C) begin
          sat_cnt_d[k*CNT_W +: CNT_W] = sat_cnt_q[k*CNT_W +: CNT_W] + CNT_ONE_C;
        end else begin
          sat_cnt_d[k*CNT_W +: CNT_W] = CNT_MAX_C;
        end
      end else begin
        sat_flag_d[k]               = sat_flag_q[k];
        sat_cnt_d[k*CNT_W +: CNT_W] = sat_cnt_q[k*CNT_W +: CNT_W];
      end
    end
  end

  // State registers; reset clears the pipeline so in-flight samples are lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_data_q   <= {(CH*W1){1'b0}};
      s1_valid_q  <= 1'b0;
      out_q       <= {(CH*RO){1'b0}};
      out_valid_q <= 1'b0;
      sat_pos_q   <= {CH{1'b0}};
      sat_neg_q   <= {CH{1'b0}};
      sat_flag_q  <= {CH{1'b0}};
      sat_cnt_q   <= {(CH*CNT_W){1'b0}};
    end else begin
      s1_data_q   <= s1_data_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      sat_pos_q   <= sat_pos_d;
      sat_neg_q   <= sat_neg_d;
      sat_flag_q  <= sat_flag_d;
      sat_cnt_q   <= sat_cnt_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat_pos   = sat_pos_q;
  assign bus.sat_neg   = sat_neg_q;
  assign bus.sat_flag  = sat_flag_q;
  assign bus.sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_satprotect_pipe.sv
// tb_satprotect_pipe: directed vectors with a queue scoreboard.
// Stimulus pushes expected samples (with due cycle); monitors pop on out_valid.
// u_dut uses SHIFT=0, u_dut2 uses SHIFT=2 for the scaling/rounding vectors.
module tb_satprotect_pipe;
  localparam int RI = 16, RO = 14, CH = 2, CNT_W = 8;

`ifdef SATPROTECT_ROUND_EN
  localparam int R6 = 2, RM6 = -1, R7 = 2, RM7 = -2;
`else
  localparam int R6 = 1, RM6 = -2, R7 = 1, RM7 = -2;
`endif

  typedef struct {
    logic [CH*RO-1:0] out;
    logic [CH-1:0]    pos;
    logic [CH-1:0]    neg;
    int               due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  satprotect_pipe_if #(.RI(RI), .RO(RO), .CH(CH), .CNT_W(CNT_W)) bus ();
  satprotect_pipe_if #(.RI(RI), .RO(RO), .CH(CH), .CNT_W(CNT_W)) bus2 ();

  satprotect_pipe #(.RI(RI), .RO(RO), .SHIFT(0), .CH(CH), .CNT_W(CNT_W)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  satprotect_pipe #(.RI(RI), .RO(RO), .SHIFT(2), .CH(CH), .CNT_W(CNT_W)) u_dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  // Monitor for u_dut: every presented sample must match the queue head on time.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      vectors++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL dut1_unexpected: out_valid=1 out=%h at cycle %0d, expected no sample", bus.out, cyc);
      end else begin
        e1 = q1.pop_front();
        if (bus.out !== e1.out || bus.sat_pos !== e1.pos || bus.sat_neg !== e1.neg || cyc != e1.due) begin
          errors++;
          $display("FAIL dut1_sample: got out=%h pos=%b neg=%b cyc=%0d, expected out=%h pos=%b neg=%b cyc=%0d",
                   bus.out, bus.sat_pos, bus.sat_neg, cyc, e1.out, e1.pos, e1.neg, e1.due);
        end
      end
    end
  end

  // Monitor for u_dut2 (SHIFT=2).
  always @(negedge clk) begin
    if (bus2.out_valid === 1'b1) begin
      vectors++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL dut2_unexpected: out_valid=1 out=%h at cycle %0d, expected no sample", bus2.out, cyc);
      end else begin
        e2 = q2.pop_front();
        if (bus2.out !== e2.out || bus2.sat_pos !== e2.pos || bus2.sat_neg !== e2.neg || cyc != e2.due) begin
          errors++;
          $display("FAIL dut2_sample: got out=%h pos=%b neg=%b cyc=%0d, expected out=%h pos=%b neg=%b cyc=%0d",
                   bus2.out, bus2.sat_pos, bus2.sat_neg, cyc, e2.out, e2.pos, e2.neg, e2.due);
        end
      end
    end
  end

  task automatic drive(input int a, input int b, input logic v, input logic c);
    @(posedge clk); #1;
    bus.in        = {b[RI-1:0], a[RI-1:0]};
    bus.in_valid  = v;
    bus.clr       = c;
    bus2.in_valid = 1'b0;
  endtask

  task automatic drive2(input int a, input int b);
    @(posedge clk); #1;
    bus2.in       = {b[RI-1:0], a[RI-1:0]};
    bus2.in_valid = 1'b1;
    bus.in_valid  = 1'b0;
    bus.clr       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0);
  endtask

  function automatic exp_t mk(input int o0, input int o1, input logic [1:0] p, input logic [1:0] n);
    exp_t e;
    e.out = {o1[RO-1:0], o0[RO-1:0]};
    e.pos = p;
    e.neg = n;
    e.due = cyc + 2;
    return e;
  endfunction

  task automatic push(input int o0, input int o1, input logic [1:0] p, input logic [1:0] n);
    q1.push_back(mk(o0, o1, p, n));
  endtask

  task automatic push2(input int o0, input int o1);
    q2.push_back(mk(o0, o1, 2'b00, 2'b00));
  endtask

  task automatic check_stat(input string name, input logic [CH-1:0] flg, input int c0, input int c1);
    logic [CH*CNT_W-1:0] ec;
    ec = {c1[CNT_W-1:0], c0[CNT_W-1:0]};
    @(negedge clk);
    vectors++;
    if (bus.sat_flag !== flg || bus.sat_cnt !== ec) begin
      errors++;
      $display("FAIL %s: got flag=%b cnt=%h, expected flag=%b cnt=%h", name, bus.sat_flag, bus.sat_cnt, flg, ec);
    end
  endtask

  task automatic check_hold(input int o0, input int o1, input logic [1:0] p, input logic [1:0] n);
    logic [CH*RO-1:0] eo;
    eo = {o1[RO-1:0], o0[RO-1:0]};
    @(negedge clk);
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.out !== eo || bus.sat_pos !== p || bus.sat_neg !== n) begin
      errors++;
      $display("FAIL hold: got v=%b out=%h pos=%b neg=%b, expected v=0 out=%h pos=%b neg=%b",
               bus.out_valid, bus.out, bus.sat_pos, bus.sat_neg, eo, p, n);
    end
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.sat_pos !== '0 || bus.sat_neg !== '0 ||
        bus.sat_flag !== '0 || bus.sat_cnt !== '0) begin
      errors++;
      $display("FAIL %s: got out=%h v=%b pos=%b neg=%b flag=%b cnt=%h, expected all zero",
               name, bus.out, bus.out_valid, bus.sat_pos, bus.sat_neg, bus.sat_flag, bus.sat_cnt);
    end
  endtask

  initial begin
    bus.in = '0;  bus.in_valid = 1'b0;  bus.clr = 1'b0;
    bus2.in = '0; bus2.in_valid = 1'b0; bus2.clr = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    check_zero("reset_state");
    rst = 1'b1;

    // In-range pass-through.
    drive(8191, 0, 1'b1, 1'b0); push(8191, 0, 2'b00, 2'b00);
    idle(3);
    check_stat("no_sat_status", 2'b00, 0, 0);

    // Both clamp directions.
    drive(8192, -8193, 1'b1, 1'b0); push(8191, -8192, 2'b01, 2'b10);
    idle(3);
    check_stat("first_sat_status", 2'b11, 1, 1);

    // Mixed patterns with a bubble.
    drive(-8192, 100, 1'b1, 1'b0);     push(-8192, 100, 2'b00, 2'b00);
    drive(32767, -32768, 1'b1, 1'b0);  push(8191, -8192, 2'b01, 2'b10);
    drive(0, 0, 1'b0, 1'b0);
    drive(-1, 8191, 1'b1, 1'b0);       push(-1, 8191, 2'b00, 2'b00);
    drive(-8193, 8192, 1'b1, 1'b0);    push(-8192, 8191, 2'b10, 2'b01);
    idle(3);
    check_stat("mixed_status", 2'b11, 3, 3);

    // clr alone.
    drive(0, 0, 1'b0, 1'b1);
    idle(2);
    check_stat("clr_alone", 2'b00, 0, 0);

    // clr coincident with a ch0 event, ch1 holding a prior count.
    drive(0, 9000, 1'b1, 1'b0);  push(0, 8191, 2'b10, 2'b00);
    drive(9000, 0, 1'b1, 1'b0);  push(8191, 0, 2'b01, 2'b00);
    drive(0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    idle(2);
    check_stat("clr_coincident", 2'b01, 1, 0);

    // Counter saturation on ch0, ch1 parked at one.
    drive(0, 0, 1'b0, 1'b1);
    idle(1);
    drive(0, -9000, 1'b1, 1'b0); push(0, -8192, 2'b00, 2'b10);
    for (int i = 0; i < 300; i++) begin
      drive(20000, 5, 1'b1, 1'b0); push(8191, 5, 2'b01, 2'b00);
    end
    idle(3);
    check_hold(8191, 5, 2'b01, 2'b00);
    check_stat("cnt_at_max", 2'b11, 255, 1);
    drive(-20000, 5, 1'b1, 1'b0); push(-8192, 5, 2'b00, 2'b01);
    idle(3);
    check_stat("cnt_held", 2'b11, 255, 1);

    // SHIFT=2 scaling.
    drive2(6, -6);          push2(R6, RM6);
    drive2(7, -7);          push2(R7, RM7);
    drive2(32764, -32768);  push2(8191, -8192);
    idle(4);

    // Reset mid-stream: A is presented, B and C are in flight.
    drive(9000, -9000, 1'b1, 1'b0); push(8191, -8192, 2'b01, 2'b10);
    drive(111, 222, 1'b1, 1'b0);
    drive(333, 444, 1'b1, 1'b0);
    @(negedge clk); #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(5);
    drive(1234, -1234, 1'b1, 1'b0); push(1234, -1234, 2'b00, 2'b00);
    idle(4);

    // Everything pushed must have been seen.
    vectors++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d samples outstanding, expected 0/0", q1.size(), q2.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
